// File: rtl/clcg_word_gen.sv
// Dual coupled-LCG pseudorandom generator: four shift-add LCGs feed a CLCG or
// decimated dual-CLCG bit stream, packed MSB-first into words on a valid/ready port.
module clcg_word_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = 3,
  parameter int unsigned WORD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] q0,
  input  logic [SW-1:0]    r1,
  input  logic [SW-1:0]    r2,
  input  logic [SW-1:0]    r3,
  input  logic [SW-1:0]    r4,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] b3,
  input  logic [WIDTH-1:0] b4,
  output logic [WORD-1:0]  out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = (WORD > 1) ? $clog2(WORD) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] x, y, p, q;
  logic [SW-1:0]    rx, ry, rp, rq;
  logic [WIDTH-1:0] bx, by, bp, bq;
  logic             run_mode;
  logic [WORD-2:0]  acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x_n, y_n, p_n, q_n;
  logic             bit_b, bit_c, emit, last, stall;
  logic [WORD-1:0]  acc_n;

  // One LCG step: s*(2^r + 1) + b, wrapped to WIDTH bits.
  function automatic logic [WIDTH-1:0] lcg_step(input logic [WIDTH-1:0] s,
                                                input logic [SW-1:0]    sh,
                                                input logic [WIDTH-1:0] inc);
    return s + (s << sh) + inc;
  endfunction

  always_comb begin
    x_n   = lcg_step(x, rx, bx);
    y_n   = lcg_step(y, ry, by);
    p_n   = lcg_step(p, rp, bp);
    q_n   = lcg_step(q, rq, bq);
    bit_b = (x_n > y_n);
    bit_c = (p_n > q_n);
    emit  = !run_mode || !bit_c;
    last  = (cnt == CW'(WORD - 1));
    // Freeze only when the next emitted bit would overwrite an unconsumed word.
    stall = out_valid && !out_ready && last;
    acc_n = {acc, bit_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      p         <= '0;
      q         <= '0;
      rx        <= '0;
      ry        <= '0;
      rp        <= '0;
      rq        <= '0;
      bx        <= '0;
      by        <= '0;
      bp        <= '0;
      bq        <= '0;
      run_mode  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (start) begin
        state    <= RUN;
        busy     <= 1'b1;
        x        <= x0;
        y        <= y0;
        p        <= p0;
        q        <= q0;
        rx       <= r1;
        ry       <= r2;
        rp       <= r3;
        rq       <= r4;
        bx       <= b1;
        by       <= b2;
        bp       <= b3;
        bq       <= b4;
        run_mode <= mode;
        acc      <= '0;
        cnt      <= '0;
      end else if (state == RUN && !stall) begin
        x <= x_n;
        y <= y_n;
        p <= p_n;
        q <= q_n;
        if (emit) begin
          acc <= acc_n[WORD-2:0];
          if (last) begin
            // Completion overrides a same-cycle consume: no bubble.
            out_word  <= acc_n;
            out_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/clcg_word_gen.md
# clcg_word_gen

Parametrised dual coupled-LCG pseudorandom generator with word output. It is the successor to the single-bit coupled-LCG generators in the PRBG family. Four shift-add LCGs run in lock-step. In mode 0 the generator produces one comparison bit per cycle (CLCG). In mode 1 it produces a variable-rate, decimated bit stream (dual-CLCG). Bits are packed into WORD-bit words and delivered over a valid/ready handshake, with back-pressure stalling the generators.

## Interface
- WIDTH, 8, LCG state and constant width
- SW, 3, shift-amount width (multiplier a = 2^r + 1)
- WORD, 8, output word width in bits
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse: latch seeds/constants, enter RUN
- mode  in  1  0 = CLCG, 1 = dual-CLCG; sampled only with start
- x0, y0, p0, q0  in  WIDTH each  seeds
- r1, r2, r3, r4  in  SW each  shift amounts for x, y, p, q
- b1, b2, b3, b4  in  WIDTH each  additive constants for x, y, p, q
- out_word  out  WORD  packed word, first-generated bit in MSB
- out_valid  out  1  out_word holds an unconsumed word
- out_ready  in  1  consumer accepts when out_valid & out_ready at the edge
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN.
  - rst → IDLE. Clears x, y, p, q, coefficients, accumulator, bit count, out_word, out_valid and busy to 0.
  - IDLE + start → RUN. Loads seeds, r*, b* and mode into internal registers, clears the accumulator and count, and does not advance the LCGs.
  - RUN + start → restart: same loads. out_word and out_valid are untouched; a pending word survives.
  - No exit from RUN except rst.
- Advance (RUN, not stalled, no start): s ← s + (s << r) + b, truncated mod 2^WIDTH, for each of the four LCGs.
- Comparison bits use the new values. B = (x_new > y_new), unsigned. C = (p_new > q_new).
- Emission:
  - Mode 0: B is emitted every advance.
  - Mode 1: B is emitted only when C = 0; otherwise nothing is emitted that cycle.
- Packing: acc ← {acc[WORD-2:0], B}, and count increments. When count reaches WORD, {acc, B} loads into out_word, out_valid sets and count resets to 0.
- Handshake:
  - out_valid clears on out_valid & out_ready, unless a new word completes in the same cycle; in that case out_valid stays 1 with the new word.
  - out_word is stable while out_valid & !out_ready.
- Stall: stall = out_valid & !out_ready & (count == WORD-1). While stalled, the LCGs, acc and count freeze. In mode 1 the stall applies even if C would have suppressed the bit.
- rst has priority over start. start has priority over advance.

## Timing
- start sampled at edge k → state loaded at k. First advance at k+1.
- Mode 0 with out_ready = 1: out_valid rises after edge k+WORD, then one new word every WORD cycles.
- Mode 1: latency equals WORD emitted bits, which varies.
- A handshake and a word completion in the same cycle cause no bubble and no lost word.
- rst mid-RUN: all outputs are 0 the cycle after the edge, and any pending word is discarded.

## Test plan
- WIDTH=8, WORD=8, mode 0, x0=25 r1=4 b1=47, y0=15 r2=2 b2=23, out_ready=1, start at edge k.
  - Required: out_valid first high after edge k+8 with out_word=0xF4.
  - Internal x sequence 216,135,38,181,52,163,2,81.
- Mode 1, same x/y, with p0=0 r3=0 b3=0 (p stays 0) and q0=13 r4=3 b4=23.
  - Required: C never 1, so the output is identical to mode 0 (0xF4 after k+8).
- Mode 1 with q0=0 r4=0 b4=0 and p0=1 r3=0 b3=1 (p > q always).
  - Required: out_valid stays 0 for 200 cycles while busy=1.
- Mode 0, out_ready=0.
  - Required: 0xF4 held stable, and the LCGs freeze after 15 advances (x frozen).
  - Raising out_ready for one cycle consumes 0xF4, and the next word loads on the same edge with out_valid still 1.
- Restart and reset mid-RUN.
  - Pulse start 3 cycles after the first start: count restarts, and 0xF4 appears 8 advances after the second start.
  - Then assert rst while out_valid=1: out_valid, out_word and busy are 0 on the next cycle.
